// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input word selector feeding a 2-entry elastic output buffer with error counting
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_cnt,
  input  logic                    clr_cnt
);
  localparam int PW = (2**SEL_W)*WIDTH;
  localparam logic [SEL_W:0] NIN = NUM_IN[SEL_W:0];
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, TWO = 2'b11} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] bus_pad;
  logic [WIDTH-1:0] beat_data, skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic skid_err, hit, acc, dlv, load_main, from_skid, load_skid;
  // zero-padding to a full power-of-two bus keeps every select index in range
  assign bus_pad = PW'(in_bus);
  assign hit = {1'b0, sel} < NIN;
  assign beat_data = hit ? bus_pad[sel*WIDTH +: WIDTH] : DEFAULT_VAL;
  assign acc = in_valid & in_ready;
  assign dlv = out_valid & out_ready;
  assign out_valid = state_q[1];
  always_comb begin
    state_d = state_q;
    load_main = 1'b0;
    from_skid = 1'b0;
    load_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        state_d = acc ? ONE : EMPTY;
        load_main = acc;
      end
      ONE: begin
        state_d = acc ? (dlv ? ONE : TWO) : (dlv ? EMPTY : ONE);
        load_main = acc & dlv;
        load_skid = acc & ~dlv;
      end
      TWO: begin
        state_d = dlv ? ONE : TWO;
        load_main = dlv;
        from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      in_ready <= 1'b1;
      out_data <= '0;
      out_sel <= '0;
      out_err <= 1'b0;
      skid_data <= '0;
      skid_sel <= '0;
      skid_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      in_ready <= state_d != TWO;
      if (load_main)
        {out_err, out_sel, out_data} <= from_skid ? {skid_err, skid_sel, skid_data} : {~hit, sel, beat_data};
      if (load_skid)
        {skid_err, skid_sel, skid_data} <= {~hit, sel, beat_data};
      if (clr_cnt)
        err_cnt <= '0;
      else if (acc && !hit && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed checks of selection, back-pressure, throughput, counter and reset
module tb_mux_n_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic [95:0] in_bus;
  logic [1:0] sel;
  logic in_valid, in_ready, out_err, out_valid, out_ready, clr_cnt;
  logic [31:0] out_data;
  logic [1:0] out_sel, err_cnt;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(32'hDEADBEEF), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {in_ready, out_valid, out_err, out_sel, out_data}
  function automatic logic [63:0] pk(logic r, logic v, logic e, logic [1:0] s, logic [31:0] d);
    return {27'd0, r, v, e, s, d};
  endfunction

  initial begin
    logic [31:0] ed;
    rst_n = 1'b0; in_bus = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    #12;
    chk("reset_out", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(1, 0, 0, 0, 0));
    chk("reset_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    // basic select
    in_bus = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sel2", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(1, 1, 0, 2, 32'hCCCC0002));
    step();
    chk("sel2_drain", 64'(out_valid), 64'd0);
    // out-of-range select
    sel = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("oor", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(1, 1, 1, 3, 32'hDEADBEEF));
    chk("oor_cnt", 64'(err_cnt), 64'd1);
    step();
    // back-pressure
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    step();
    chk("bp_one", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(1, 1, 0, 0, 32'hAAAA0000));
    sel = 2'd1;
    step();
    chk("bp_two", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(0, 1, 0, 0, 32'hAAAA0000));
    sel = 2'd2;
    step();
    chk("bp_hold", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(0, 1, 0, 0, 32'hAAAA0000));
    out_ready = 1'b1;
    step();
    chk("bp_d1", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(1, 1, 0, 1, 32'hBBBB0001));
    step();
    in_valid = 1'b0;
    chk("bp_d2", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(1, 1, 0, 2, 32'hCCCC0002));
    step();
    chk("bp_empty", pk(in_ready, out_valid, 0, 0, 0), pk(1, 0, 0, 0, 0));
    // throughput: 100 beats, one per cycle
    for (int c = 0; c < 100; c++) begin
      in_bus = {32'hC0000000 | 32'(c), 32'hB0000000 | 32'(c), 32'hA0000000 | 32'(c)};
      sel = 2'(c % 4); in_valid = 1'b1;
      ed = (c % 4 == 0) ? 32'hA0000000 | 32'(c) : (c % 4 == 1) ? 32'hB0000000 | 32'(c) :
           (c % 4 == 2) ? 32'hC0000000 | 32'(c) : 32'hDEADBEEF;
      step();
      chk($sformatf("tp_%0d", c), pk(in_ready, out_valid, out_err, out_sel, out_data),
          pk(1, 1, c % 4 == 3, 2'(c % 4), ed));
    end
    in_valid = 1'b0;
    step();
    chk("tp_end", 64'(out_valid), 64'd0);
    chk("tp_cnt_sat", 64'(err_cnt), 64'd3);
    // counter saturation and clear priority
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr", 64'(err_cnt), 64'd0);
    sel = 2'd3; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("cnt_%0d", i), 64'(err_cnt), 64'(i > 3 ? 3 : i));
    end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0; in_valid = 1'b0;
    chk("clr_wins", 64'(err_cnt), 64'd0);
    chk("clr_beat", pk(0, out_valid, out_err, out_sel, out_data), pk(0, 1, 1, 3, 32'hDEADBEEF));
    step();
    // reset mid-flight in state TWO
    in_bus = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
    step();
    sel = 2'd0;
    step();
    in_valid = 1'b0;
    chk("rst_pre", pk(in_ready, out_valid, 0, 0, 0), pk(0, 1, 0, 0, 0));
    chk("rst_pre_cnt", 64'(err_cnt), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", pk(in_ready, out_valid, out_err, out_sel, out_data), pk(1, 0, 0, 0, 0));
    chk("rst_async_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_quiet_%0d", i), pk(in_ready, out_valid, 0, 0, 0), pk(1, 0, 0, 0, 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
Parametrised N-input, W-bit-wide selector with a registered output stage and valid/ready handshake. It replaces the flat combinational 2:1 word mux wherever a selection feeds a pipeline boundary, for example operand, writeback or PC-source select in the 32-bit datapath. A 2-entry elastic buffer (main register plus skid register) sustains one beat per cycle under back-pressure. Out-of-range selects are flagged per beat and counted.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 4, number of input channels (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
DEFAULT_VAL, 0, output data value for an out-of-range select
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_bus  input  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  channel index, sampled with in_valid
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat
out_data  output  WIDTH  selected word
out_sel  output  SEL_W  select value that produced out_data
out_err  output  1  beat was produced by an out-of-range sel
out_valid  output  1  out_data, out_sel and out_err are valid
out_ready  input  1  downstream accepts the beat
err_cnt  output  CNT_W  saturating count of accepted out-of-range beats
clr_cnt  input  1  synchronous clear of err_cnt

Behaviour:
- Clock and reset: single clock domain (clk); reset is asynchronous, active-low (rst_n). All state is cleared immediately on rst_n low.
- Reset values: out_data=0, out_sel=0, out_err=0, out_valid=0, err_cnt=0, skid empty, in_ready=1.
- Handshakes:
  - Accept: in_valid & in_ready at a rising edge.
  - Deliver: out_valid & out_ready at a rising edge.
- Selection on accept:
  - If sel < NUM_IN: data = in_bus[sel*WIDTH +: WIDTH], err = 0.
  - Otherwise: data = DEFAULT_VAL, err = 1.
  - The selected data, sel and err are captured together as one beat.
- Latency: 1 cycle. A beat accepted at edge t appears on the outputs after edge t, when the main register is empty or drains at t.
- States, as a function of {main_valid, skid_valid}:
  - EMPTY {0,0}: accept -> ONE.
  - ONE {1,0}:
    - accept & deliver -> ONE, new beat in main.
    - accept & !deliver -> TWO, new beat in skid.
    - deliver only -> EMPTY.
  - TWO {1,1}:
    - in_ready=0, no accept.
    - deliver -> ONE: skid moves to main, skid clears.
- in_ready is a register equal to !skid_valid of the next state. It is never combinationally dependent on out_ready.
- out_valid = main_valid. Outputs hold stable while out_valid=1 and out_ready=0.
- Beat order is strictly preserved. No beat is dropped or duplicated.
- Full throughput: with out_ready held at 1, one beat is delivered per cycle.
- Sampling rules:
  - in_bus and sel are sampled only at the accept edge; changes at other times have no effect.
  - in_valid may drop without being accepted.
- err_cnt:
  - Increments by 1 on each accepted beat with err=1.
  - Saturates at 2**CNT_W-1.
  - clr_cnt=1 sets it to 0 at the next edge. If clr_cnt coincides with an erroring accept, the result is 0 (clear wins).
- When NUM_IN = 2**SEL_W, out_err is always 0 and DEFAULT_VAL is unreachable.
- Reset mid-operation: buffered beats are discarded, outputs return to reset values at once, and no spurious delivery occurs after release.

Test Plan:
1. Basic select: NUM_IN=4, in_bus={0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, sel=2, out_ready=1 -> out_data=0xCCCC0002, out_sel=2, out_err=0 one cycle after accept.
2. Out-of-range: NUM_IN=3, SEL_W=2, DEFAULT_VAL=0xDEADBEEF, sel=3 -> out_data=0xDEADBEEF, out_err=1, err_cnt=1.
3. Back-pressure: out_ready=0, stream sel=0,1,2 with in_valid=1 -> two beats held, then in_ready=0. Raising out_ready delivers channels 0,1,2 in order with no gaps, and in_ready returns to 1.
4. Throughput: out_ready=1, 100 back-to-back beats with sel cycling 0..3 -> 100 deliveries in 101 cycles, data matches a scoreboard.
5. Counter: CNT_W=2, 5 erroring beats -> err_cnt sticks at 3. Asserting clr_cnt in the same cycle as a 6th erroring accept -> err_cnt=0.
6. Reset mid-flight: buffer in state TWO, pulse rst_n low between edges -> out_valid=0 and in_ready=1 immediately, err_cnt=0, no old beat appears afterwards.
